instr_fetch: RTL

Fetch stage that owns the architectural PC register and feeds the branch/PC-update stage. It issues word-addressed requests to instruction memory over a req/ack handshake, latches the returned word, and splits it into the fields the branch stage consumes: opcode, func, imm and branch_sig. It holds the instruction until that stage returns the next PC with the update strobe, then fetches again. A flush path redirects fetch immediately, and a timeout reports a hung memory.

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/instr_decode.sv | 30 +++
 rtl/instr_fetch.sv | 100 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/branch definitions: opcodes, branch classes, fetch FSM states, field positions.
// No logic; latency n/a.
// Backpressure n/a.
package fetch_pkg;

    localparam logic [5:0] OPC_JMP   = 6'h20;
    localparam logic [5:0] OPC_BCOND = 6'h21;
    localparam logic [5:0] OPC_CALL  = 6'h22;
    localparam logic [5:0] OPC_JR    = 6'h23;
    localparam logic [5:0] OPC_HALT  = 6'h24;

    typedef enum logic [2:0] {
        BR_NONE  = 3'b000,
        BR_JMP   = 3'b001,
        BR_BCOND = 3'b010,
        BR_CALL  = 3'b011,
        BR_JR    = 3'b100,
        BR_HALT  = 3'b101
    } br_sig_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        ERR   = 2'd2
    } fetch_state_t;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int IMM_MSB  = 21;
    localparam int IMM_LSB  = 6;
    localparam int IMM_W    = IMM_MSB - IMM_LSB + 1;

endpackage

// File: rtl/instr_decode.sv
// Splits an instruction word into opcode/func/sign-extended imm and classifies the branch type.
// Latency: purely combinational.
// Backpressure: none; outputs follow instr.
module instr_decode
    import fetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] imm,
    output logic [2:0]  branch_sig
);

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign func   = instr[FUNC_MSB:FUNC_LSB];
    assign imm    = {{(32 - IMM_W){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};

    always_comb begin
        branch_sig = BR_NONE;
        case (opcode)
            OPC_JMP:   branch_sig = BR_JMP;
            OPC_BCOND: branch_sig = BR_BCOND;
            OPC_CALL:  branch_sig = BR_CALL;
            OPC_JR:    branch_sig = BR_JR;
            OPC_HALT:  branch_sig = BR_HALT;
            default:   branch_sig = BR_NONE;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches one word over req/ack, holds it decoded until update_pc/flush.
// Latency: instr_valid rises the cycle after imem_ack; next request the cycle after update_pc.
// Backpressure: holds the instruction indefinitely until update_pc; flush redirects at any time.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        update_pc,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_q,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] imm,
    output logic [2:0]  branch_sig,
    output logic        fetch_err
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    fetch_state_t state;
    logic [15:0]  cnt;
    logic         discard;
    logic         req_live;

    // A flushed request stays outstanding in memory; we stop asking until its ack drains.
    assign req_live  = (state == FETCH) && !discard;
    assign imem_req  = req_live && !rst;
    assign imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            state       <= FETCH;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            discard     <= 1'b0;
            cnt         <= '0;
        end else if (flush) begin
            pc_q        <= next_pc;
            instr_valid <= 1'b0;
            cnt         <= '0;
            state       <= FETCH;
            fetch_err   <= 1'b0;
            // An ack in the flush cycle is simply dropped; only a still-pending request needs draining.
            discard     <= (state == FETCH) && !imem_ack && (discard || req_live);
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        cnt <= '0;
                        if (discard) begin
                            discard <= 1'b0;
                        end else begin
                            instr       <= imem_rdata;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= ERR;
                        fetch_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (update_pc) begin
                        pc_q        <= next_pc;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                ERR: begin
                end
                default: state <= FETCH;
            endcase
        end
    end

    instr_decode u_decode (
        .instr      (instr),
        .opcode     (opcode),
        .func       (func),
        .imm        (imm),
        .branch_sig (branch_sig)
    );

endmodule
